// File: rtl/spi_lcd_stream_rx.sv
// spi_lcd_stream_rx: passive SPI mode-0 slave that deframes chip-select
// transactions into an LCD command/data byte stream (first byte rs=0,
// following bytes rs=1). Bytes go through a first-word-fall-through FIFO
// with a valid/ready handshake.
// Optional feature macro: SPI_LCD_FRAME_SYNC_EN. When it is defined, a
// 0x2C command at the FIFO head is held until the next lcd_fmark rising edge.
module spi_lcd_stream_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_sck,
  input  logic                          spi_mosi,
  input  logic                          spi_cs,
  input  logic                          lcd_fmark,
  output logic [7:0]                    out_data,
  output logic                          out_rs,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  // Tracks how far real pin samples have propagated since reset, so the idle
  // value loaded into the cs chain is never mistaken for a real cs level.
  logic [SYNC_STAGES-1:0] sync_ok_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;
  logic                   armed_q;

  logic sck_s, mosi_s, cs_s;
  logic sck_rise, cs_fall, cs_rise, bit_rise;

  // Synchronizer chains, loaded with bus-idle levels on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sync_ok_q   <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sync_ok_q   <= {sync_ok_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign bit_rise = sck_rise & ~cs_s;

  // Arm framing once cs has genuinely been seen high after reset; a reset in
  // the middle of a transaction must not restart deframing until cs toggles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (sync_ok_q[SYNC_STAGES-1] && cs_s) begin
      armed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic       byte_done;
  // Seven stored bits; the eighth comes straight from mosi on the completing
  // edge, so the full byte is {shift_q, mosi_s}.
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       push_q;
  logic [7:0] push_byte_q;
  logic       push_rs_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and byte-completion decode
  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD, ST_DATA: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (bit_rise && bit_cnt_q == 3'd7) begin
          byte_done = 1'b1;
          state_d   = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit shifter, bit counter and one-cycle push register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      push_rs_q   <= 1'b0;
    end else begin
      push_q <= byte_done;
      if (byte_done) begin
        push_byte_q <= {shift_q, mosi_s};
        push_rs_q   <= (state_q == ST_DATA);
      end
      if (state_q == ST_IDLE && cs_fall) begin
        bit_cnt_q <= '0;
      end else if (bit_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [8:0]    head;
  logic          not_empty, full, pop, push_ok;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (level_q != '0);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok   = push_q & (~full | pop);

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (push_q & full & ~pop);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr_q] <= {push_rs_q, push_byte_q};
    end
  end

  // Head is masked to zero while empty so outputs are defined after reset
  assign out_data   = not_empty ? head[7:0] : 8'h00;
  assign out_rs     = not_empty ? head[8]   : 1'b0;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

`ifdef SPI_LCD_FRAME_SYNC_EN
  // ---------------------------------------------------------------------
  // Frame sync: hold a memory-write command at the head until fmark rises
  // ---------------------------------------------------------------------
  logic [1:0] fm_sync_q;
  logic       fm_prev_q;
  logic       released_q, released_d;
  logic       fm_rise, head_is_ramwr;

  assign fm_rise       = fm_sync_q[1] & ~fm_prev_q;
  assign head_is_ramwr = not_empty & ~head[8] & (head[7:0] == 8'h2C);

  // An fmark edge counts only while the 0x2C is already the head; the
  // release is cleared when that entry leaves the FIFO.
  always_comb begin
    released_d = released_q | (head_is_ramwr & fm_rise);
    if (pop) begin
      released_d = 1'b0;
    end
  end

  // fmark synchronizer and release flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fm_sync_q  <= '0;
      fm_prev_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      fm_sync_q  <= {fm_sync_q[0], lcd_fmark};
      fm_prev_q  <= fm_sync_q[1];
      released_q <= released_d;
    end
  end

  assign out_valid = not_empty & ~(head_is_ramwr & ~released_q);
`else
  logic unused_fmark;
  assign unused_fmark = lcd_fmark;
  assign out_valid    = not_empty;
`endif

endmodule

// File: tb/tb_spi_lcd_stream_rx.sv
// Bench for spi_lcd_stream_rx: directed SPI transactions, a byte-level
// deframing model, and a per-cycle compare of the output stream.
module tb_spi_lcd_stream_rx;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs = 1'b1;
  logic       lcd_fmark = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_rs;
  logic       out_valid;
  logic       overflow;
  logic [4:0] fifo_level;

  spi_lcd_stream_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs(spi_cs), .lcd_fmark(lcd_fmark), .out_data(out_data),
    .out_rs(out_rs), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Expected stream (written by stimulus) and observed pops (written by compare)
  logic [8:0] exp_mem [0:511];
  int         exp_wr = 0;
  int         exp_rd = 0;
  logic [8:0] got_mem [0:511];
  int         got_n = 0;

  // Model of the deframer: bits counted per transaction
  logic       m_armed = 1'b1;
  logic       m_frame = 1'b0;
  int         m_bits = 0;
  int         m_nbytes = 0;
  logic [7:0] m_sr = 8'h00;
  logic       m_ovf = 1'b0;
  logic       lat_v3 = 1'b0;
  logic       lat_v4 = 1'b0;

  int ready_mode = 0;  // 0 = low, 1 = high, 2 = toggle every cycle

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // out_ready driver, changes just after the active edge
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ~out_ready;
    endcase
  end

  // Compare process: every cycle with out_valid the head must match the model
  logic       prev_stall = 1'b0;
  logic [8:0] prev_head = 9'h000;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd = exp_wr;
      prev_stall = 1'b0;
    end else begin
`ifndef SPI_LCD_FRAME_SYNC_EN
      chk("valid_vs_level", int'(out_valid), int'(fifo_level != 0));
`endif
      if (out_valid) begin
        if (exp_rd >= exp_wr) begin
          chk("spurious_out", int'({out_rs, out_data}), 'h1000);
        end else begin
          chk("head", int'({out_rs, out_data}), int'(exp_mem[exp_rd]));
        end
        if (prev_stall) begin
          chk("stall_hold", int'({out_rs, out_data}), int'(prev_head));
        end
        if (out_ready) begin
          got_mem[got_n] = {out_rs, out_data};
          got_n++;
          if (exp_rd < exp_wr) exp_rd++;
        end
      end else if (prev_stall) begin
        chk("stall_valid_drop", 0, 1);
      end
      prev_stall = out_valid & ~out_ready;
      prev_head  = {out_rs, out_data};
    end
  end

  task automatic model_push(input logic [8:0] e);
    if (exp_wr - exp_rd < DEPTH) begin
      exp_mem[exp_wr] = e;
      exp_wr++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // Send the top n bits of v, MSB first, 8 clk per SPI bit (mode 0)
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = v[7-i];
      tick(4);
      spi_sck = 1'b1;
      if (m_frame) begin
        m_sr = {m_sr[6:0], v[7-i]};
        m_bits++;
        if (m_bits == 8) begin
          model_push({(m_nbytes > 0) ? 1'b1 : 1'b0, m_sr});
          m_nbytes++;
          m_bits = 0;
        end
      end
      tick(3);
      lat_v3 = out_valid;
      tick(1);
      lat_v4 = out_valid;
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    m_frame = m_armed;
    m_bits = 0;
    m_nbytes = 0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs = 1'b1;
    m_frame = 1'b0;
    m_armed = 1'b1;
    tick(8);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    m_frame = 1'b0;
    m_armed = spi_cs;
    m_ovf = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_rd == exp_wr && !out_valid && fifo_level == 0) && n < 3000) begin
      tick(1);
      n++;
    end
    chk(name, int'(n < 3000), 1);
  endtask

  initial begin
    int g;
    // Reset state
    tick(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_rs", int'(out_rs), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_level", int'(fifo_level), 0);
    rst_n = 1'b1;
    tick(5);

    // Basic transaction: command + two data bytes
    ready_mode = 1;
    g = got_n;
    cs_low();
    send_byte(8'h2A);
    send_byte(8'h00);
    send_byte(8'hEF);
    cs_high();
    drain("t1_drain_timeout");
    chk("t1_count", got_n - g, 3);
    chk("t1_b0", int'(got_mem[g]), 'h02A);
    chk("t1_b1", int'(got_mem[g+1]), 'h100);
    chk("t1_b2", int'(got_mem[g+2]), 'h1EF);
    chk("t1_level", int'(fifo_level), 0);

    // Fill to full with the writer stalled, then overflow on the 17th byte
    ready_mode = 0;
    tick(2);
    g = got_n;
    cs_low();
    send_byte(8'h2B);
    chk("t2_lat_before", int'(lat_v3), 0);
    chk("t2_lat_at", int'(lat_v4), 1);
    for (int i = 0; i < 15; i++) send_byte(8'h40 + 8'(i));
    tick(6);
    chk("t2_level_full", int'(fifo_level), 16);
    chk("t2_ovf_before", int'(overflow), 0);
    send_byte(8'h4F);
    cs_high();
    chk("t2_level_after", int'(fifo_level), 16);
    chk("t2_ovf_after", int'(overflow), 1);
    chk("t2_ovf_model", int'(overflow), int'(m_ovf));
    ready_mode = 1;
    drain("t2_drain_timeout");
    chk("t2_count", got_n - g, 16);
    chk("t2_first", int'(got_mem[g]), 'h02B);
    chk("t2_last", int'(got_mem[g+15]), 'h14E);

    // Partial second byte is discarded; next transaction starts with rs=0
    g = got_n;
    cs_low();
    send_byte(8'hB0);
    send_bits(8'h55, 5);
    cs_high();
    cs_low();
    send_byte(8'h36);
    send_byte(8'h48);
    cs_high();
    drain("t3_drain_timeout");
    chk("t3_count", got_n - g, 3);
    chk("t3_b0", int'(got_mem[g]), 'h0B0);
    chk("t3_b1", int'(got_mem[g+1]), 'h036);
    chk("t3_b2", int'(got_mem[g+2]), 'h148);

    // Reset mid-byte in DATA with cs held low
    chk("t4_ovf_sticky", int'(overflow), 1);
    g = got_n;
    cs_low();
    send_byte(8'h11);
    send_byte(8'h22);
    drain("t4_pre_drain_timeout");
    send_bits(8'h99, 5);
    pulse_reset();
    tick(2);
    chk("t4_ovf_cleared", int'(overflow), 0);
    chk("t4_level_rst", int'(fifo_level), 0);
    send_bits(8'h20, 3);
    send_byte(8'h77);
    send_byte(8'h88);
    tick(10);
    chk("t4_no_out_level", int'(fifo_level), 0);
    chk("t4_no_out_valid", int'(out_valid), 0);
    cs_high();
    cs_low();
    send_byte(8'h3A);
    send_byte(8'h55);
    cs_high();
    drain("t4_drain_timeout");
    chk("t4_count", got_n - g, 4);
    chk("t4_b0", int'(got_mem[g]), 'h011);
    chk("t4_b1", int'(got_mem[g+1]), 'h122);
    chk("t4_b2", int'(got_mem[g+2]), 'h03A);
    chk("t4_b3", int'(got_mem[g+3]), 'h155);

    // 64-byte burst with out_ready toggling every cycle
    ready_mode = 2;
    g = got_n;
    cs_low();
    send_byte(8'h3C);
    for (int i = 0; i < 64; i++) send_byte(8'(i * 37 + 5));
    cs_high();
    ready_mode = 1;
    drain("t5_drain_timeout");
    chk("t5_count", got_n - g, 65);
    chk("t5_first", int'(got_mem[g]), 'h03C);
    chk("t5_second", int'(got_mem[g+1]), 'h105);
    chk("t5_last", int'(got_mem[g+64]), 'h120);

`ifdef SPI_LCD_FRAME_SYNC_EN
    // Memory-write command waits for an fmark edge seen while it is the head
    lcd_fmark = 1'b1;
    tick(3);
    lcd_fmark = 1'b0;
    tick(3);
    g = got_n;
    cs_low();
    send_byte(8'h2C);
    send_byte(8'h12);
    cs_high();
    tick(20);
    chk("t6_held_valid", int'(out_valid), 0);
    chk("t6_held_level", int'(fifo_level), 2);
    lcd_fmark = 1'b1;
    tick(4);
    lcd_fmark = 1'b0;
    drain("t6_drain_timeout");
    chk("t6_count", got_n - g, 2);
    chk("t6_b0", int'(got_mem[g]), 'h02C);
    chk("t6_b1", int'(got_mem[g+1]), 'h112);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_lcd_stream_rx.md
Name: spi_lcd_stream_rx

Overview:
- SPI slave receiver on the host SPI pins (spi_sck/spi_mosi/spi_cs), oversampled in the HFOSC `clk` domain.
- Deframes each chip-select transaction: first byte is an LCD command (rs=0), all following bytes are parameter/pixel data (rs=1).
- Buffers bytes in a FIFO and presents a valid/ready byte stream to the downstream `lcd` bus writer, which drives lcd_data/lcd_rs/lcd_wr.
- Listens passively alongside the PSRAM passthrough; never drives spi_miso.

Parameters:
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on sck, mosi and cs; minimum 2.

Ports:
- clk  input  1  system clock (SB_HFOSC, 48 MHz)
- rst_n  input  1  reset; synchronous, active-low
- spi_sck  input  1  host SPI clock; mode 0; max frequency clk/6
- spi_mosi  input  1  host SPI data, MSB first
- spi_cs  input  1  host chip select, active-low
- lcd_fmark  input  1  LCD tearing-effect pulse (optional feature only)
- out_data  output  8  byte to LCD writer
- out_rs  output  1  0 = command byte, 1 = data byte
- out_valid  output  1  FIFO head valid
- out_ready  input  1  LCD writer accepts head
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied; state IDLE; bit counter 0; synchronizers loaded with idle values (sck=0, cs=1, mosi=0).
  - Reset values: out_valid=0, out_data=0, out_rs=0, overflow=0, fifo_level=0.
  - Reset mid-transaction: the partial byte and the rest of that transaction are discarded. Deframing restarts only at the next cs falling edge.
- Synchronize sck, mosi and cs through SYNC_STAGES flops. Detect edges on the synchronized signals.
  - On a sck rising edge with cs low: shift mosi into an 8-bit shift register (MSB first) and increment the 3-bit bit counter.
  - Rising edges seen while cs is high are ignored.
- States:
  - IDLE: cs falling edge -> CMD; bit counter cleared.
  - CMD: 8th bit -> push {rs=0, byte}; go to DATA.
  - DATA: each 8th bit -> push {rs=1, byte}; stay in DATA.
  - CMD or DATA: cs rising edge -> IDLE. A partial byte (counter != 0) is discarded silently.
- Push occurs 1 clk after the sck edge that completes the byte. Latency from completing sck edge (at the pin) to out_valid=1 on an empty FIFO is SYNC_STAGES+2 clk.
- FIFO:
  - First-word-fall-through: out_data/out_rs reflect the head whenever out_valid=1.
  - Pop on out_valid & out_ready.
  - out_data/out_rs hold stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop when full: push accepted, level unchanged, no overflow.
  - Simultaneous push and pop when empty: the byte is pushed; out_valid rises next cycle; no bypass.
  - Push when full without pop: byte dropped, overflow set to 1. overflow stays set until reset.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is in 0..FIFO_DEPTH.
- A cs pulse with zero bits produces no bytes. A transaction of only a command byte yields one rs=0 entry.

Optional Feature:
- Macro: SPI_LCD_FRAME_SYNC_EN.
- With the macro: when a command byte 0x2C (memory write) reaches the FIFO head, out_valid is forced 0 until the first rising edge of lcd_fmark.
  - lcd_fmark is passed through a 2-flop synchronizer first.
  - After that edge, the 0x2C and the following data flow normally.
  - Arming is per 0x2C head; an fmark edge seen before the 0x2C reaches the head does not count.
- Without the macro: lcd_fmark is unused and out_valid = FIFO not empty.

Test Plan:
- Reset, then cs low; send 0x2A, 0x00, 0xEF; cs high; out_ready=1 -> outputs (rs,data) = (0,0x2A), (1,0x00), (1,0xEF); fifo_level returns to 0.
- out_ready=0; send 1 cmd + 16 data bytes with FIFO_DEPTH=16 -> fifo_level=16; overflow=1 after the 17th byte; drain yields the first 16 bytes in order.
- cs rises after 5 bits of the second byte -> only the first byte (rs=0) appears; the next transaction's first byte is again rs=0.
- Assert rst_n=0 for one cycle mid-byte during DATA, then continue clocking bits with cs still low -> no output until cs toggles high then low; first new byte has rs=0.
- out_ready toggles 1/0 every cycle during a 64-byte data burst -> no loss, no duplication, order preserved; out_data stable while stalled.
- With SPI_LCD_FRAME_SYNC_EN: send 0x2C, 0x12 -> out_valid=0 until an lcd_fmark rising edge; then (0,0x2C), (1,0x12).
